// File: rtl/block_serializer_if.sv
// Handshake bundle for block_serializer: block load side and word stream side.
interface block_serializer_if #(
    parameter int N = 16,
    parameter int M = 16
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    logic [N-1:0]  in_block [M-1:0];
    logic          in_flip;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    modport master (
        output in_block, in_flip, in_valid, out_ready,
        input  in_ready, out_data, out_idx, out_last,
        input  out_valid, busy
    );

    modport slave (
        input  in_block, in_flip, in_valid, out_ready,
        output in_ready, out_data, out_idx, out_last,
        output out_valid, busy
    );
endinterface

// File: rtl/block_serializer.sv
// Drains one registered block of M words, one word per cycle, optionally reversed.
module block_serializer #(
    parameter int N = 16,
    parameter int M = 16
) (
    input logic               clk,
    input logic               rst,
    block_serializer_if.slave bus
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]    r_state;
    logic [N-1:0]  r_buf [M-1:0];
    logic          r_flip;
    logic [N-1:0]  r_data;
    logic [IW-1:0] r_idx;
    logic          r_valid;

    logic          w_last;
    logic          w_accept;
    logic          w_ready;
    logic          w_load;
    logic [IW-1:0] w_end;
    logic [IW-1:0] w_start;
    logic [IW-1:0] w_next;

    assign w_end    = r_flip ? '0 : LAST_IDX;
    assign w_last   = r_valid & (r_idx == w_end);
    assign w_accept = r_valid & bus.out_ready;
    // rst gates the ready so nothing is offered upstream while held in reset
    assign w_ready  = rst & ((r_state == S_IDLE) | (w_accept & w_last));
    assign w_load   = bus.in_valid & w_ready;
    assign w_start  = bus.in_flip ? LAST_IDX : '0;
    assign w_next   = r_flip ? (r_idx - 1'b1) : (r_idx + 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_flip  <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < M; i++) r_buf[i] <= '0;
        end else if (w_load) begin
            r_state <= S_SEND;
            r_flip  <= bus.in_flip;
            r_idx   <= w_start;
            r_data  <= bus.in_block[w_start];
            r_valid <= 1'b1;
            for (int i = 0; i < M; i++) r_buf[i] <= bus.in_block[i];
        end else if (w_accept && !w_last) begin
            r_idx  <= w_next;
            r_data <= r_buf[w_next];
        end else if (w_accept) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_data  = r_data;
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = w_last;
    assign bus.out_valid = r_valid;
    assign bus.busy      = (r_state == S_SEND);
endmodule

// File: tb/tb_block_serializer.sv
// Directed bench for block_serializer: M=4 streams plus an M=1 instance.
module tb_block_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    block_serializer_if #(.N(16), .M(4)) bus ();
    block_serializer_if #(.N(16), .M(1)) b1 ();

    block_serializer #(.N(16), .M(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    block_serializer #(.N(16), .M(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_word(input string tag, input int d, input int idx,
                            input bit last);
        chk({tag, "_v"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_d"}, 32'(bus.out_data), 32'(d));
        chk({tag, "_i"}, 32'(bus.out_idx), 32'(idx));
        chk({tag, "_l"}, 32'(bus.out_last), 32'(last));
    endtask

    task automatic load4(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d,
                         input logic f);
        bus.in_block[0] = a;
        bus.in_block[1] = b;
        bus.in_block[2] = c;
        bus.in_block[3] = d;
        bus.in_flip = f;
        bus.in_valid = 1'b1;
        #1;
        chk("ld_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) bus.in_block[i] = '0;
        bus.in_flip = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        b1.in_block[0] = '0;
        b1.in_flip = 1'b0;
        b1.in_valid = 1'b0;
        b1.out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_v", 32'(bus.out_valid), 32'd0);
        chk("rst_d", 32'(bus.out_data), 32'd0);
        chk("rst_i", 32'(bus.out_idx), 32'd0);
        chk("rst_l", 32'(bus.out_last), 32'd0);
        chk("rst_rdy", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("idle_rdy", 32'(bus.in_ready), 32'd1);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle1_rdy", 32'(b1.in_ready), 32'd1);

        // in order
        load4(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        chk("t2_busy", 32'(bus.busy), 32'd1);
        chk("t2_rdy", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            exp_word("t2", i + 1, i, i == 3);
            tick();
        end
        chk("t2_end_v", 32'(bus.out_valid), 32'd0);
        chk("t2_end_busy", 32'(bus.busy), 32'd0);
        chk("t2_hold_d", 32'(bus.out_data), 32'd4);
        chk("t2_hold_i", 32'(bus.out_idx), 32'd3);

        // reversed
        load4(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_word("t3", 4 - i, 3 - i, i == 3);
            tick();
        end
        chk("t3_end_v", 32'(bus.out_valid), 32'd0);

        // backpressure on word 2
        load4(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        exp_word("t4a", 1, 0, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        bus.in_block[1] = 16'h00ee;
        for (int k = 0; k < 3; k++) begin
            exp_word("t4h", 2, 1, 1'b0);
            tick();
        end
        bus.out_ready = 1'b1;
        exp_word("t4b", 2, 1, 1'b0);
        tick();
        exp_word("t4c", 3, 2, 1'b0);
        tick();
        exp_word("t4d", 4, 3, 1'b1);
        tick();
        chk("t4_end_v", 32'(bus.out_valid), 32'd0);

        // back-to-back blocks
        load4(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp_word("t5a", i + 1, i, 1'b0);
            tick();
        end
        exp_word("t5a4", 4, 3, 1'b1);
        bus.in_block[0] = 16'h000a;
        bus.in_block[1] = 16'h000b;
        bus.in_block[2] = 16'h000c;
        bus.in_block[3] = 16'h000d;
        bus.in_flip = 1'b0;
        bus.in_valid = 1'b1;
        #1;
        chk("t5_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_word("t5b", 10 + i, i, i == 3);
            tick();
        end
        chk("t5_end_v", 32'(bus.out_valid), 32'd0);

        // reset mid-block
        load4(16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
        exp_word("t6a", 1, 0, 1'b0);
        tick();
        exp_word("t6b", 2, 1, 1'b0);
        bus.in_valid = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("t6r_v", 32'(bus.out_valid), 32'd0);
        chk("t6r_d", 32'(bus.out_data), 32'd0);
        chk("t6r_i", 32'(bus.out_idx), 32'd0);
        chk("t6r_l", 32'(bus.out_last), 32'd0);
        chk("t6r_rdy", 32'(bus.in_ready), 32'd0);
        chk("t6r_busy", 32'(bus.busy), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rdy", 32'(bus.in_ready), 32'd1);
        load4(16'd5, 16'd6, 16'd7, 16'd8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_word("t6c", 5 + i, i, i == 3);
            tick();
        end
        chk("t6_end_v", 32'(bus.out_valid), 32'd0);

        // single-word blocks
        b1.in_block[0] = 16'd9;
        b1.in_valid = 1'b1;
        #1;
        chk("m1_rdy0", 32'(b1.in_ready), 32'd1);
        tick();
        b1.in_valid = 1'b0;
        chk("m1a_v", 32'(b1.out_valid), 32'd1);
        chk("m1a_d", 32'(b1.out_data), 32'd9);
        chk("m1a_i", 32'(b1.out_idx), 32'd0);
        chk("m1a_l", 32'(b1.out_last), 32'd1);
        b1.in_block[0] = 16'h0011;
        b1.in_flip = 1'b1;
        b1.in_valid = 1'b1;
        #1;
        chk("m1_rdy1", 32'(b1.in_ready), 32'd1);
        tick();
        b1.in_valid = 1'b0;
        chk("m1b_v", 32'(b1.out_valid), 32'd1);
        chk("m1b_d", 32'(b1.out_data), 32'h11);
        chk("m1b_i", 32'(b1.out_idx), 32'd0);
        chk("m1b_l", 32'(b1.out_last), 32'd1);
        tick();
        chk("m1_end_v", 32'(b1.out_valid), 32'd0);
        chk("m1_end_busy", 32'(b1.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
